// File: rtl/dmem_resp.sv
// Data-memory responder: byte-masked writes commit at the accept edge; reads return after LATENCY cycles.
// Optional DMEM_ADDR_CHECK_EN adds err_o, which flags out-of-range reads (with rvalid_o) and out-of-range writes.
module dmem_resp #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2,
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ren_i,
   input  logic        wen_i,
   input  logic [63:0] raddr_i,
   input  logic [63:0] waddr_i,
   input  logic [63:0] wdata_i,
   input  logic [7:0]  wmask_i,
   output logic [63:0] rdata_o,
   output logic        rvalid_o,
   output logic        busy_o
`ifdef DMEM_ADDR_CHECK_EN
   ,
   output logic        err_o
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [63:0] SPAN   = 64'd8 << DEPTH_LOG2;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic [63:0]           cap;
   logic [63:0]           roff;
   logic [63:0]           woff;
   logic [DEPTH_LOG2-1:0] ridx;
   logic [DEPTH_LOG2-1:0] widx;
   logic                  rin;
   logic                  win;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [63:0]           rd_word;

   // Addresses below BASE_ADDR wrap to huge offsets and so fall out of range.
   assign roff = raddr_i - BASE_ADDR;
   assign woff = waddr_i - BASE_ADDR;
   assign ridx = roff[DEPTH_LOG2+2:3];
   assign widx = woff[DEPTH_LOG2+2:3];
   assign rin  = roff < SPAN;
   assign win  = woff < SPAN;

   assign busy_o   = (state == WAIT);
   assign rvalid_o = (state == RESP);
   assign rd_acc   = !busy_o && ren_i;
   assign wr_acc   = !busy_o && wen_i;

   // Same-edge write to the word being read is forwarded into the captured data.
   always_comb begin
      rd_word = '0;
      if (rin) begin
         rd_word = mem[ridx];
         if (wen_i && win && (widx == ridx)) begin
            for (int b = 0; b < 8; b++) begin
               if (wmask_i[b]) begin
                  rd_word[8*b +: 8] = wdata_i[8*b +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc && win) begin
         for (int b = 0; b < 8; b++) begin
            if (wmask_i[b]) begin
               mem[widx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         cap     <= '0;
         rdata_o <= '0;
      end else begin
         case (state)
            WAIT: begin
               if (cnt == 4'd1) begin
                  state   <= RESP;
                  rdata_o <= cap;
                  cnt     <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               if (rd_acc) begin
                  if (LATENCY == 1) begin
                     state   <= RESP;
                     rdata_o <= rd_word;
                  end else begin
                     state <= WAIT;
                     cnt   <= LAT_M1;
                     cap   <= rd_word;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef DMEM_ADDR_CHECK_EN
   logic rerr;
   logic werr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rerr <= 1'b0;
         werr <= 1'b0;
      end else begin
         werr <= wr_acc && !win;
         if (rd_acc) begin
            rerr <= !rin;
         end
      end
   end

   assign err_o = (rvalid_o && rerr) || werr;
`endif

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the target end of the load/store request interface driven by the pipeline's mem stage.
- Holds a 64-bit-wide word array.
  - Byte-masked writes commit at the accept edge.
  - Reads return after a configurable latency.
- Drives a busy stall indication back to ctrl while a read is outstanding.
- Sits between the mem stage and the memory image; replaces the simulation-host memory calls for synthesizable builds.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 64-bit words in the array (4096 words = 32 KiB)
- LATENCY, 2, cycles from read-accept edge to rvalid_o high; legal range 1..15
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address mapped to word 0

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ren_i  in  1  read request
- wen_i  in  1  write request
- raddr_i  in  64  read byte address; bits [2:0] ignored (word-aligned access)
- waddr_i  in  64  write byte address; bits [2:0] ignored
- wdata_i  in  64  write data
- wmask_i  in  8  byte enables; bit n enables wdata_i[8n+7:8n]
- rdata_o  out  64  read data; valid when rvalid_o=1, held otherwise
- rvalid_o  out  1  one-cycle pulse marking rdata_o valid
- busy_o  out  1  read outstanding; requests ignored while high (to ctrl as stall)

Behaviour:
- Reset (rst=1 at an edge):
  - rdata_o=0, rvalid_o=0, busy_o=0, state=IDLE, latency counter=0.
  - Array contents not cleared.
  - Reset during WAIT abandons the read; no rvalid_o pulse follows.
- Word index = (addr - BASE_ADDR) >> 3, low DEPTH_LOG2 bits. In range iff (addr - BASE_ADDR) < 8*2^DEPTH_LOG2, compared as unsigned 64-bit (addresses below BASE wrap large, so out of range).
- Accept: a request is accepted at an edge where busy_o=0 and (ren_i|wen_i).
  - Inputs while busy_o=1 are ignored entirely; the initiator holds them.
- Write:
  - Commits at the accept edge to in-range words only, for bytes with wmask_i bit set.
  - wmask_i=0 is a no-op.
  - No response pulse for writes; busy_o unaffected.
- Read:
  - Data is captured at the accept edge.
  - If wen_i=1 at the same edge and the write word index equals the read word index (both in range), captured data = old word with wmask_i-selected bytes replaced by wdata_i. This is read-write conflict forwarding.
  - Out-of-range read captures 0.
- State machine:
  - IDLE: accept read → if LATENCY=1 go RESP, else go WAIT with cnt=LATENCY-1.
  - WAIT: cnt decrements each cycle; busy_o=1; when cnt reaches 1 → RESP.
  - RESP: rvalid_o=1 and rdata_o=captured data for exactly one cycle; busy_o=0.
    - A new request may be accepted in the RESP cycle (back-to-back).
    - Next state: WAIT/RESP if a read was accepted, else IDLE.
- Latency: rvalid_o rises exactly LATENCY cycles after the accept edge. busy_o is high for LATENCY-1 cycles, i.e. never when LATENCY=1.
- Write-only accepts leave state in IDLE; a write alone never asserts busy_o.
- rdata_o holds its last returned value between pulses.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- Defined:
  - Adds output port err_o (1 bit, reset 0).
  - err_o pulses with rvalid_o for an out-of-range read.
  - err_o pulses for one cycle after the accept edge of an out-of-range write, with rvalid_o=0.
- Undefined:
  - No err_o port.
  - Out-of-range reads return 0 and writes are dropped silently.

Test Plan:
- Reset, then write 0x1122334455667788 to 0x80000010 with mask 0xFF; read 0x80000010 (LATENCY=2) → busy_o=1 for 1 cycle, rvalid_o 2 cycles after accept, rdata_o=0x1122334455667788.
- Write 0xAAAAAAAAAAAAAAAA mask 0x0F to 0x80000010, then read → rdata_o=0x11223344AAAAAAAA.
- Same edge ren_i=wen_i=1, both addresses 0x80000010, wdata 0xFFFF000000000000, mask 0xC0, prior word 0x11223344AAAAAAAA → rdata_o=0xFFFF3344AAAAAAAA; subsequent read returns the same value.
- Read 0x80000008 while busy_o=1 with a new address on raddr_i → request ignored; back-to-back read issued in the RESP cycle is accepted and its rvalid_o follows LATENCY cycles later.
- Read 0x7FFFFFF8 and 0x80008000 → rdata_o=0; with DMEM_ADDR_CHECK_EN, err_o=1 with each rvalid_o.
- rst=1 one cycle after a read accept (LATENCY=4) → busy_o=0 next cycle, no rvalid_o, array word unchanged.
